sd_block_reader: RTL and testbench
==================================

SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter: TOKEN_TRIES, 1024, maximum byte reads spent waiting for the start token.
REQ-002 SHALL have ports, in this order:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a 512-byte block read.
- active  out  1  high while a block read is in progress.
- done  out  1  one-cycle completion pulse.
- error  out  2  status valid with done: 00 ok, 01 token timeout, 10 bad token, 11 CRC error.
- sh_start_read  out  1  one-cycle pulse that starts a shifter read byte.
- sh_shift_in  out  8  shifter parallel input; constant 8'hFF.
- sh_shift_out  in  8  shifter parallel output.
- sh_busy  in  1  shifter busy.
- sh_crc_reset  out  1  CRC generator reset pulse.
- sh_crc_source  out  1  CRC input select; constant 1 (MISO).
- sh_crc  in  16  CRC generator value.
- buf_we  out  1  buffer write strobe.
- buf_addr  out  9  buffer byte address.
- buf_wdata  out  8  buffer write data.

Function
REQ-003 SHALL implement states IDLE, TOK_ISSUE, TOK_WAIT, DAT_ISSUE, DAT_WAIT, CRC_ISSUE, CRC_WAIT, CHECK, FINISH.
REQ-004 SHALL leave IDLE for TOK_ISSUE on start=1; start SHALL be ignored in all other states.
REQ-005 SHALL assert active in every state except IDLE.
REQ-006 Each *_ISSUE state SHALL assert sh_start_read for exactly one cycle, but only in a cycle where sh_busy=0; while sh_busy=1 it SHALL hold with no pulse.
REQ-007 From *_ISSUE the block SHALL move to the matching *_WAIT on the cycle after the pulse; a byte is complete on the first *_WAIT cycle with sh_busy=0, and sh_shift_out SHALL be taken as the received byte in that cycle.
REQ-008 TOK_WAIT, byte complete:
- byte 8'hFF with tries < TOKEN_TRIES: return to TOK_ISSUE and increment the 11-bit try counter.
- byte 8'hFE: pulse sh_crc_reset in that cycle, clear the byte counter, go to DAT_ISSUE.
- any other byte: go to FINISH with error 10.
REQ-009 SHALL go to FINISH with error 01 when the TOKEN_TRIES-th consecutive 8'hFF is received.
REQ-010 DAT_WAIT, byte complete: buf_we=1 for one cycle, buf_addr = byte counter, buf_wdata = sh_shift_out, then increment the counter.
REQ-011 After DAT_WAIT: next state SHALL be DAT_ISSUE while the counter was < 511; after the write at address 511 the next state SHALL be CRC_ISSUE, and the counter wraps to 0.
REQ-012 SHALL read exactly two CRC bytes via CRC_ISSUE/CRC_WAIT, with a 1-bit CRC byte index, then go to CHECK; CRC bytes SHALL NOT be written to the buffer.
REQ-013 CHECK SHALL last one cycle: sh_crc == 16'h0000 -> error 00, otherwise error 11; then go to FINISH.
REQ-014 FINISH SHALL pulse done for one cycle with error valid and go to IDLE.
REQ-015 error SHALL hold its value until the next start.
REQ-016 buf_addr and buf_wdata SHALL hold their last values when buf_we=0.
REQ-017 Each received byte SHALL take at least 18 clk cycles including handshake at shifter speed clk/2.

Reset
REQ-018 rst=1 SHALL force IDLE with active=0, done=0, error=00, sh_start_read=0, sh_crc_reset=0, buf_we=0, buf_addr=0, buf_wdata=0, and both counters 0.
REQ-019 rst mid-transfer SHALL abort with no done pulse; start SHALL be accepted on the first cycle after rst deasserts.

Verification
REQ-020 Bench SHALL cover these scenarios with a shifter model:
- MISO = 3x FF, FE, 512 bytes of value i[7:0], then a valid CRC16-CCITT -> 512 buf_we pulses with addr i and data i[7:0], done with error 00, exactly 4 token reads.
- Same stream with one data bit flipped -> all 512 writes occur, done with error 11.
- MISO constant FF -> exactly 1024 token reads, no buf_we, done with error 01.
- Token byte 05 after 2x FF -> done with error 10, no buf_we, no sh_crc_reset.
- rst pulsed during the byte at address 100 -> all outputs return to reset values, no done; a following start completes normally.
- start held high for the whole transfer -> only one transfer runs; sh_start_read is never asserted while sh_busy=1.

Source files
------------

// File: rtl/sd_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : sd_block_reader
// Purpose  : Reads one 512-byte SD data block through a byte shifter. It waits
//            for the FE start token, writes the data bytes into a buffer and
//            checks the trailing CRC16 with an external CRC generator.
// Revision : 1.0 - initial release
// ============================================================================
module sd_block_reader #(
  parameter int TOKEN_TRIES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        active,
  output logic        done,
  output logic [1:0]  error,
  output logic        sh_start_read,
  output logic [7:0]  sh_shift_in,
  input  logic [7:0]  sh_shift_out,
  input  logic        sh_busy,
  output logic        sh_crc_reset,
  output logic        sh_crc_source,
  input  logic [15:0] sh_crc,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_wdata
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TOK_ISSUE = 4'd1,
    TOK_WAIT  = 4'd2,
    DAT_ISSUE = 4'd3,
    DAT_WAIT  = 4'd4,
    CRC_ISSUE = 4'd5,
    CRC_WAIT  = 4'd6,
    CHECK     = 4'd7,
    FINISH    = 4'd8
  } state_t;

  // Index of the final permitted FF: receiving FF with this many FFs already
  // seen is the TOKEN_TRIES-th consecutive FF and ends in a timeout.
  localparam logic [10:0] c_LAST_TRY = 11'(TOKEN_TRIES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_tries;
  logic [8:0]  r_cnt;
  logic        r_crc_idx;
  logic [1:0]  r_error;
  logic [8:0]  r_addr_q;
  logic [7:0]  r_data_q;

  logic        w_start_rd;
  logic        w_crc_rst;
  logic        w_we;
  logic        w_done;
  logic        w_set_err;
  logic [1:0]  w_err_val;
  logic        w_begin;
  logic        w_tries_inc;
  logic        w_cnt_clr;
  logic        w_idx_inc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the one-cycle control strobes.
  always_comb begin
    w_next      = r_state;
    w_start_rd  = 1'b0;
    w_crc_rst   = 1'b0;
    w_we        = 1'b0;
    w_done      = 1'b0;
    w_set_err   = 1'b0;
    w_err_val   = 2'b00;
    w_begin     = 1'b0;
    w_tries_inc = 1'b0;
    w_cnt_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_begin   = 1'b1;
          w_set_err = 1'b1;
          w_next    = TOK_ISSUE;
        end
      end
      TOK_ISSUE: begin
        if (!sh_busy) begin
          w_start_rd = 1'b1;
          w_next     = TOK_WAIT;
        end
      end
      TOK_WAIT: begin
        if (!sh_busy) begin
          if (sh_shift_out == 8'hFE) begin
            w_crc_rst = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = DAT_ISSUE;
          end else if (sh_shift_out == 8'hFF) begin
            if (r_tries == c_LAST_TRY) begin
              w_set_err = 1'b1;
              w_err_val = 2'b01;
              w_next    = FINISH;
            end else begin
              w_tries_inc = 1'b1;
              w_next      = TOK_ISSUE;
            end
          end else begin
            w_set_err = 1'b1;
            w_err_val = 2'b10;
            w_next    = FINISH;
          end
        end
      end
      DAT_ISSUE: begin
        if (!sh_busy) begin
          w_start_rd = 1'b1;
          w_next     = DAT_WAIT;
        end
      end
      DAT_WAIT: begin
        if (!sh_busy) begin
          w_we   = 1'b1;
          w_next = (r_cnt == 9'd511) ? CRC_ISSUE : DAT_ISSUE;
        end
      end
      CRC_ISSUE: begin
        if (!sh_busy) begin
          w_start_rd = 1'b1;
          w_next     = CRC_WAIT;
        end
      end
      CRC_WAIT: begin
        if (!sh_busy) begin
          w_idx_inc = 1'b1;
          w_next    = r_crc_idx ? CHECK : CRC_ISSUE;
        end
      end
      CHECK: begin
        w_set_err = 1'b1;
        w_err_val = (sh_crc == 16'h0000) ? 2'b00 : 2'b11;
        w_next    = FINISH;
      end
      FINISH: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counters, status and the held buffer address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tries   <= 11'd0;
      r_cnt     <= 9'd0;
      r_crc_idx <= 1'b0;
      r_error   <= 2'b00;
      r_addr_q  <= 9'd0;
      r_data_q  <= 8'd0;
    end else begin
      if (w_begin) begin
        r_tries   <= 11'd0;
        r_cnt     <= 9'd0;
        r_crc_idx <= 1'b0;
      end
      if (w_tries_inc) r_tries <= r_tries + 11'd1;
      if (w_cnt_clr)   r_cnt   <= 9'd0;
      if (w_we) begin
        r_cnt    <= r_cnt + 9'd1;
        r_addr_q <= r_cnt;
        r_data_q <= sh_shift_out;
      end
      if (w_idx_inc) r_crc_idx <= ~r_crc_idx;
      if (w_set_err) r_error   <= w_err_val;
    end
  end

  assign active        = (r_state != IDLE);
  assign done          = w_done;
  assign error         = r_error;
  assign sh_start_read = w_start_rd;
  assign sh_shift_in   = 8'hFF;
  assign sh_crc_reset  = w_crc_rst;
  assign sh_crc_source = 1'b1;
  assign buf_we        = w_we;
  assign buf_addr      = w_we ? r_cnt : r_addr_q;
  assign buf_wdata     = w_we ? sh_shift_out : r_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_block_reader
// Purpose  : Directed bench for sd_block_reader with a clk/2 shifter and
//            CRC16-CCITT generator model feeding a stored MISO byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_block_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        active, done;
  logic [1:0]  error;
  logic        sh_start_read, sh_crc_reset, sh_crc_source;
  logic [7:0]  sh_shift_in;
  logic [7:0]  sh_shift_out;
  logic        sh_busy;
  logic [15:0] sh_crc;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sd_block_reader #(.TOKEN_TRIES(1024)) u_dut (
    .clk(clk), .rst(rst), .start(start), .active(active), .done(done),
    .error(error), .sh_start_read(sh_start_read), .sh_shift_in(sh_shift_in),
    .sh_shift_out(sh_shift_out), .sh_busy(sh_busy), .sh_crc_reset(sh_crc_reset),
    .sh_crc_source(sh_crc_source), .sh_crc(sh_crc), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata)
  );

  // MISO stream; bytes beyond stream_len read as FF.
  logic [7:0] stream   [0:1023];
  logic [7:0] exp_data [0:511];
  int         stream_len = 0;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Shifter model: busy 16 cycles after a start pulse, then presents the byte.
  logic        m_load = 1'b0;
  int          m_idx, m_bcnt;
  logic [15:0] m_crc;
  logic [7:0]  w_byte;
  assign w_byte = (m_idx < stream_len) ? stream[m_idx] : 8'hFF;
  assign sh_crc = m_crc;

  always @(posedge clk) begin
    if (m_load || rst) begin
      sh_busy      <= 1'b0;
      sh_shift_out <= 8'hFF;
      m_idx        <= 0;
      m_bcnt       <= 0;
      m_crc        <= 16'h0000;
    end else begin
      if (sh_start_read) begin
        sh_busy <= 1'b1;
        m_bcnt  <= 15;
      end else if (sh_busy) begin
        if (m_bcnt == 0) begin
          sh_busy      <= 1'b0;
          sh_shift_out <= w_byte;
          m_crc        <= crc_upd(m_crc, w_byte);
          m_idx        <= m_idx + 1;
        end else begin
          m_bcnt <= m_bcnt - 1;
        end
      end
      if (sh_crc_reset) m_crc <= 16'h0000;
    end
  end

  // Output monitor, sampled on the falling edge.
  int         n_tok, n_wr, n_wrbad, n_hold_bad, n_crr, n_done, n_viol;
  logic       seen_cr;
  logic [1:0] last_err;
  logic [8:0] last_addr;
  logic [7:0] last_data;

  always @(negedge clk) begin
    if (m_load) begin
      n_tok = 0; n_wr = 0; n_wrbad = 0; n_hold_bad = 0; n_crr = 0; n_done = 0;
      seen_cr = 1'b0; last_err = 2'b00; last_addr = 9'd0; last_data = 8'd0;
    end else if (!rst) begin
      if (sh_start_read) begin
        if (sh_busy) n_viol++;
        if (!seen_cr) n_tok++;
      end
      if (sh_crc_reset) begin
        n_crr++;
        seen_cr = 1'b1;
      end
      if (buf_we) begin
        if (n_wr >= 512) n_wrbad++;
        else if (buf_addr != 9'(n_wr) || buf_wdata != exp_data[n_wr]) n_wrbad++;
        last_addr = buf_addr;
        last_data = buf_wdata;
        n_wr++;
      end else if (n_wr > 0 && (buf_addr != last_addr || buf_wdata != last_data)) begin
        n_hold_bad++;
      end
      if (done) begin
        n_done++;
        last_err = error;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_model();
    @(posedge clk); #1;
    m_load = 1'b1;
    @(posedge clk); #1;
    m_load = 1'b0;
  endtask

  // FF FF FF FE, 512 bytes i[7:0] (optionally one bit flipped), CRC hi, lo.
  task automatic build_block(input bit flip);
    logic [15:0] c;
    c = 16'h0000;
    stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'hFF; stream[3] = 8'hFE;
    for (int i = 0; i < 512; i++) begin
      stream[4 + i] = 8'(i);
      c = crc_upd(c, 8'(i));
    end
    if (flip) stream[4 + 200] = stream[4 + 200] ^ 8'h10;
    for (int i = 0; i < 512; i++) exp_data[i] = stream[4 + i];
    stream[516] = c[15:8];
    stream[517] = c[7:0];
    stream_len  = 518;
  endtask

  task automatic pulse_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Waits for done (bounded); drops start on done so held starts run once.
  task automatic wait_done(input string tag, input int limit);
    int c;
    c = 0;
    while (n_done == 0 && c < limit) begin
      @(negedge clk);
      #1;
      if (n_done != 0) start = 1'b0;
      c++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(n_done), 32'd1);
    repeat (40) @(negedge clk);
    check({tag, "_single_done"}, 32'(n_done), 32'd1);
    check({tag, "_idle"}, {31'd0, active}, 32'd0);
  endtask

  initial begin
    int c;
    n_viol = 0;
    // Reset state
    #1;
    check("rst_outputs", {20'd0, active, done, error, sh_start_read, sh_crc_reset,
                          buf_we, buf_addr[0], 4'd0}, 32'd0);
    check("rst_addr_data", {15'd0, buf_addr, buf_wdata}, 32'd0);
    check("shift_in_const", {24'd0, sh_shift_in}, 32'hFF);
    check("crc_source_const", {31'd0, sh_crc_source}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: good block
    build_block(1'b0);
    load_model();
    pulse_start(1'b0);
    #1;
    check("s1_active", {31'd0, active}, 32'd1);
    wait_done("s1", 25000);
    check("s1_err", {30'd0, last_err}, 32'd0);
    check("s1_writes", 32'(n_wr), 32'd512);
    check("s1_wr_content", 32'(n_wrbad), 32'd0);
    check("s1_hold", 32'(n_hold_bad), 32'd0);
    check("s1_tokens", 32'(n_tok), 32'd4);
    check("s1_crc_reset", 32'(n_crr), 32'd1);
    check("s1_last_addr", {23'd0, buf_addr}, 32'd511);
    check("s1_last_data", {24'd0, buf_wdata}, 32'hFF);

    // 2: flipped data bit -> CRC error
    build_block(1'b1);
    load_model();
    pulse_start(1'b0);
    wait_done("s2", 25000);
    check("s2_err", {30'd0, last_err}, 32'd3);
    check("s2_writes", 32'(n_wr), 32'd512);
    check("s2_wr_content", 32'(n_wrbad), 32'd0);
    repeat (20) @(negedge clk);
    check("s2_err_hold", {30'd0, error}, 32'd3);

    // 3: MISO stuck at FF -> token timeout
    stream_len = 0;
    load_model();
    pulse_start(1'b0);
    wait_done("s3", 25000);
    check("s3_err", {30'd0, last_err}, 32'd1);
    check("s3_tokens", 32'(n_tok), 32'd1024);
    check("s3_writes", 32'(n_wr), 32'd0);

    // 4: bad token 05 after two FF
    stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'h05;
    stream_len = 3;
    load_model();
    pulse_start(1'b0);
    wait_done("s4", 2000);
    check("s4_err", {30'd0, last_err}, 32'd2);
    check("s4_writes", 32'(n_wr), 32'd0);
    check("s4_crc_reset", 32'(n_crr), 32'd0);
    check("s4_tokens", 32'(n_tok), 32'd3);

    // 5: reset during the byte at address 100, then restart at once
    build_block(1'b0);
    load_model();
    pulse_start(1'b0);
    c = 0;
    while (n_wr < 100 && c < 25000) begin
      @(negedge clk);
      c++;
    end
    check("s5_reached_100", 32'(n_wr), 32'd100);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("s5_rst_outputs", {26'd0, active, done, error, sh_start_read, sh_crc_reset}, 32'd0);
    check("s5_rst_buf", {14'd0, buf_we, buf_addr, buf_wdata}, 32'd0);
    repeat (4) @(negedge clk);
    check("s5_no_done", 32'(n_done), 32'd0);
    load_model();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("s5_restart_active", {31'd0, active}, 32'd1);
    wait_done("s5", 25000);
    check("s5_err", {30'd0, last_err}, 32'd0);
    check("s5_writes", 32'(n_wr), 32'd512);
    check("s5_wr_content", 32'(n_wrbad), 32'd0);
    check("s5_tokens", 32'(n_tok), 32'd4);

    // 6: start held high for the whole transfer
    build_block(1'b0);
    load_model();
    pulse_start(1'b1);
    wait_done("s6", 25000);
    check("s6_err", {30'd0, last_err}, 32'd0);
    check("s6_writes", 32'(n_wr), 32'd512);
    check("s6_tokens", 32'(n_tok), 32'd4);
    check("s6_crc_reset", 32'(n_crr), 32'd1);
    check("busy_violations", 32'(n_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
